// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcode constants, the canonical NOP and the
// hazard controller state encoding.
package core_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/rs_use_decode.sv
// Extracts rs1/rs2 indices from the IF/ID instruction and flags which of them
// the opcode actually reads, so immediates never raise false hazards.
module rs_use_decode
    import core_pkg::*;
(
    input  logic [31:0] if_id_instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        rs1_used,
    output logic        rs2_used
);

    logic [6:0] opcode;
    logic       unused_instr_bits;

    assign opcode            = if_id_instr[6:0];
    assign rs1               = if_id_instr[19:15];
    assign rs2               = if_id_instr[24:20];
    assign unused_instr_bits = ^{if_id_instr[31:25], if_id_instr[14:7]};

    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (opcode)
            LUI, AUIPC, JAL:   rs1_used = 1'b0;
            OP, STORE, BRANCH: rs2_used = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush controller with stall-cycle counter. Define
// HAZARD_MDU_EN to build the MDU wait state, watchdog and mdu_timeout flag.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_id_instr,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_write_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [15:0] WD_MAX = 16'(MDU_TIMEOUT);

    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used;
    logic       load_use;
    logic       mdu_start, mdu_fin;

    hz_state_t        state_q, state_d, state_eff;
    logic [15:0]      wd_q, wd_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    rs_use_decode u_rs_use_decode (
        .if_id_instr (if_id_instr),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used)
    );

`ifdef HAZARD_MDU_EN
    assign mdu_start = ex_mdu_start;
    assign mdu_fin   = mdu_done;
`else
    logic unused_mdu_inputs;
    assign unused_mdu_inputs = ex_mdu_start ^ mdu_done;
    assign mdu_start         = 1'b0;
    assign mdu_fin           = 1'b0;
`endif

    assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((rs1_used && (rs1 == id_ex_rd)) ||
                       (rs2_used && (rs2 == id_ex_rd)));

    // While rst is asserted the outputs decode as RUN even if the flop is still in MDU_WAIT.
    assign state_eff = rst ? RUN : state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        stall_d   = pc_write_en ? stall_q : stall_q + CNT_W'(1);
        case (state_q)
            RUN: begin
                if (mdu_start && !mdu_fin) begin
                    state_d = MDU_WAIT;
                    wd_d    = 16'd1;
                end
            end
            MDU_WAIT: begin
                if (mdu_fin) begin
                    state_d = RUN;
                    wd_d    = '0;
                end else if (wd_q == WD_MAX) begin
                    state_d   = RUN;
                    wd_d      = '0;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        if (state_eff == MDU_WAIT) begin
            // The cycle mdu_done is seen already runs unstalled.
            if (!mdu_fin) begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_write_en = 1'b0;
            end
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
        end
    end

    assign mdu_timeout  = timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan steps followed by
// random traffic, compared every cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int TO = 8;
    localparam int CW = 32;
`ifdef HAZARD_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   if_id_instr;
    logic          id_ex_mem_read;
    logic [4:0]    id_ex_rd;
    logic          ex_branch_taken;
    logic          ex_mdu_start;
    logic          mdu_done;
    logic          pc_write_en, if_id_write_en, id_ex_write_en;
    logic          if_id_flush, id_ex_flush, mdu_timeout;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_id_instr     (if_id_instr),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rd        (id_ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_mdu_start    (ex_mdu_start),
        .mdu_done        (mdu_done),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .id_ex_write_en  (id_ex_write_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mdu_timeout     (mdu_timeout),
        .stall_cycles    (stall_cycles)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: whether the core is waiting on the MDU, how many cycles it
    // has waited, the sticky watchdog flag and the running stall count.
    bit          m_wait;
    int          m_waited;
    bit          m_to;
    int unsigned m_stall;
    bit          e_pc, e_ifid, e_idex, e_iff, e_idf;

    function automatic bit reads_rs1(logic [6:0] opc);
        return !(opc == 7'h37 || opc == 7'h17 || opc == 7'h6f);
    endfunction

    function automatic bit reads_rs2(logic [6:0] opc);
        return (opc == 7'h33 || opc == 7'h23 || opc == 7'h63);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(bit r, logic [31:0] ins, bit mr, logic [4:0] rd, bit br, bit st, bit dn);
        rst             = r;
        if_id_instr     = ins;
        id_ex_mem_read  = mr;
        id_ex_rd        = rd;
        ex_branch_taken = br;
        ex_mdu_start    = st;
        mdu_done        = dn;
    endtask

    task automatic predict();
        bit hz;
        logic [6:0] opc;
        opc = if_id_instr[6:0];
        hz = id_ex_mem_read && (id_ex_rd != 5'd0) &&
             ((reads_rs1(opc) && if_id_instr[19:15] == id_ex_rd) ||
              (reads_rs2(opc) && if_id_instr[24:20] == id_ex_rd));
        {e_pc, e_ifid, e_idex, e_iff, e_idf} = 5'b11100;
        if (m_wait && !rst) begin
            if (!mdu_done) {e_pc, e_ifid, e_idex} = 3'b000;
        end else if (ex_branch_taken) begin
            {e_iff, e_idf} = 2'b11;
        end else if (hz) begin
            {e_pc, e_ifid, e_idf} = 3'b001;
        end
    endtask

    task automatic cyc(string tag);
        @(negedge clk);
        predict();
        chk({tag, ".pc_write_en"},    32'(pc_write_en),    32'(e_pc));
        chk({tag, ".if_id_write_en"}, 32'(if_id_write_en), 32'(e_ifid));
        chk({tag, ".id_ex_write_en"}, 32'(id_ex_write_en), 32'(e_idex));
        chk({tag, ".if_id_flush"},    32'(if_id_flush),    32'(e_iff));
        chk({tag, ".id_ex_flush"},    32'(id_ex_flush),    32'(e_idf));
        chk({tag, ".mdu_timeout"},    32'(mdu_timeout),    32'(m_to));
        chk({tag, ".stall_cycles"},   stall_cycles,        m_stall);
        @(posedge clk);
        if (rst) begin
            m_wait = 0; m_waited = 0; m_to = 0; m_stall = 0;
        end else begin
            if (!e_pc) m_stall++;
            if (m_wait) begin
                if (mdu_done) m_wait = 0;
                else if (m_waited == TO) begin m_wait = 0; m_to = 1; end
                else m_waited++;
            end else if (MDU_EN && ex_mdu_start && !mdu_done) begin
                m_wait = 1; m_waited = 1;
            end
        end
        #1;
    endtask

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADD_657  = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] ADDI_105 = {12'd5, 5'd0, 3'd0, 5'd1, 7'h13};
    localparam logic [31:0] LUI_X5   = 32'h0002_82b7;
    localparam logic [31:0] SW_X5    = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'h23};

    initial begin
        int unsigned base;
        logic [6:0] opcs [9];
        logic [31:0] ins;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};

        drv(1, NOP, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        m_wait = 0; m_waited = 0; m_to = 0; m_stall = 0;
        drv(1, ADD_657, 1, 5, 0, 0, 0);
        cyc("reset_decode");

        // Load-use: one bubble, then normal flow.
        drv(0, ADD_657, 1, 5, 0, 0, 0);
        cyc("load_use");
        drv(0, ADD_657, 0, 0, 0, 0, 0);
        cyc("load_use_next");
        chk("load_use_stall_count", stall_cycles, 32'd1);

        drv(0, SW_X5, 1, 5, 0, 0, 0);
        cyc("store_rs2_hazard");
        drv(0, ADDI_105, 1, 0, 0, 0, 0);
        cyc("rd_zero_no_stall");
        drv(0, LUI_X5, 1, 5, 0, 0, 0);
        cyc("lui_no_stall");
        drv(0, ADD_657, 1, 5, 1, 0, 0);
        cyc("branch_over_load_use");

        // MDU: start at cycle 0, done at cycle 5.
        base = stall_cycles;
        drv(0, NOP, 0, 0, 0, 1, 0);
        cyc("mdu_c0");
        for (int i = 1; i <= 4; i++) begin
            drv(0, ADD_657, 1, 5, 1, 0, 0);
            cyc("mdu_wait");
        end
        drv(0, NOP, 0, 0, 0, 0, 1);
        cyc("mdu_done");
        drv(0, NOP, 0, 0, 0, 0, 0);
        cyc("mdu_after");
        chk("mdu_stall_total", stall_cycles - base, MDU_EN ? 32'd4 : 32'd0);

        drv(0, NOP, 0, 0, 0, 1, 1);
        cyc("start_with_done");
        drv(0, NOP, 0, 0, 0, 0, 0);
        cyc("start_with_done_next");

        // Watchdog: no mdu_done ever arrives.
        base = stall_cycles;
        drv(0, NOP, 0, 0, 0, 1, 0);
        cyc("wd_start");
        drv(0, NOP, 0, 0, 0, 0, 0);
        for (int i = 0; i < TO + 3; i++) cyc("wd_run");
        chk("wd_stall_total", stall_cycles - base, MDU_EN ? 32'(TO) : 32'd0);
        chk("wd_sticky", 32'(mdu_timeout), 32'(MDU_EN));
        drv(1, NOP, 0, 0, 0, 0, 0);
        cyc("wd_reset");
        drv(0, NOP, 0, 0, 0, 0, 0);
        cyc("wd_cleared");

        // Reset while waiting on the MDU.
        drv(0, NOP, 0, 0, 0, 1, 0);
        cyc("rst_wait_c0");
        drv(0, NOP, 0, 0, 0, 0, 0);
        cyc("rst_wait_c1");
        cyc("rst_wait_c2");
        drv(1, NOP, 0, 0, 0, 0, 0);
        cyc("rst_wait_c3");
        drv(0, NOP, 0, 0, 0, 0, 0);
        cyc("rst_wait_c4");

        for (int i = 0; i < 500; i++) begin
            ins = $urandom;
            ins[6:0]   = opcs[$urandom_range(0, 8)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            drv(($urandom_range(0, 63) == 0), ins, $urandom_range(0, 1),
                5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
            cyc("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the 5-stage RV32I core. It sits beside the ID stage and watches the instruction in the IF/ID register, the ID/EX load destination, EX branch resolution and the multi-cycle MDU. It drives the stall enables consumed by the fetch stage (`pc_write_en`, `if_id_write_en`) and the bubble/flush controls for the downstream pipeline registers. It also keeps a stall-cycle performance counter and an MDU watchdog.

## Interface
Parameters:
- `MDU_TIMEOUT`, 64: maximum cycles spent in MDU_WAIT before the watchdog trips; legal range 2..65535.
- `CNT_W`, 32: width of `stall_cycles`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `if_id_instr` in 32: instruction held in the IF/ID register.
- `id_ex_mem_read` in 1: the instruction in ID/EX is a load.
- `id_ex_rd` in 5: destination register of the instruction in ID/EX.
- `ex_branch_taken` in 1: branch or jump resolved taken in EX; same net as fetch `branch_taken`.
- `ex_mdu_start` in 1: single-cycle pulse when a MUL/DIV instruction enters EX.
- `mdu_done` in 1: single-cycle pulse when the MDU result is valid.
- `pc_write_en` out 1: PC update enable.
- `if_id_write_en` out 1: IF/ID register update enable.
- `id_ex_write_en` out 1: ID/EX register update enable.
- `if_id_flush` out 1: load NOP (32'h00000013) into IF/ID.
- `id_ex_flush` out 1: insert a bubble into ID/EX.
- `mdu_timeout` out 1: sticky watchdog flag.
- `stall_cycles` out CNT_W: count of cycles in which `pc_write_en` was 0.

## Operation
- The FSM has two states. RUN is the reset state; MDU_WAIT is the other.
- Enables and flushes are combinational from the current state and the inputs, so they take effect in the same cycle. State, the watchdog counter, `mdu_timeout` and `stall_cycles` are registered.
- Source-register usage is decoded from `opcode = if_id_instr[6:0]`:
  - rs1 is used unless the opcode is LUI, AUIPC or JAL.
  - rs2 is used only for OP, STORE and BRANCH.
- Load-use hazard: `id_ex_mem_read && id_ex_rd != 0` and `id_ex_rd` matches a used rs field.
- Priority in RUN:
  1. `ex_branch_taken`: `if_id_flush=1`, `id_ex_flush=1`, all enables 1.
  2. Load-use: `pc_write_en=0`, `if_id_write_en=0`, `id_ex_flush=1`, `id_ex_write_en=1`.
  3. Otherwise all enables 1 and both flushes 0.
- RUN to MDU_WAIT: taken on `ex_mdu_start && !mdu_done`. The watchdog loads 1.
- In MDU_WAIT:
  - `pc_write_en`, `if_id_write_en` and `id_ex_write_en` are 0; both flushes are 0.
  - `ex_branch_taken` and load-use are ignored.
  - The watchdog increments each cycle.
- MDU_WAIT to RUN on `mdu_done`. The enables return to 1 in that same cycle.
- MDU_WAIT to RUN on watchdog == `MDU_TIMEOUT`. `mdu_timeout` is set and holds until `rst`.
- `ex_mdu_start` together with `mdu_done` in RUN: no stall, stay in RUN.
- `stall_cycles` increments on every cycle with `pc_write_en==0` and wraps modulo 2^CNT_W.

## Timing
- Reset values: state RUN, watchdog 0, `mdu_timeout=0`, `stall_cycles=0`.
- During reset the outputs show RUN decode of the current inputs.
- Load-use bubble: exactly 1 cycle. The load advances to MEM, so the hazard clears the next cycle.
- MDU stall: starts the cycle after `ex_mdu_start` and lasts until the cycle `mdu_done` is seen, inclusive of neither endpoint as a stall.
- Worst-case MDU stall is `MDU_TIMEOUT` cycles.
- `rst` in MDU_WAIT: returns to RUN on the next edge, watchdog cleared.

## Configuration
- `HAZARD_MDU_EN` defined: MDU_WAIT, the watchdog and `mdu_timeout` are implemented as above.
- `HAZARD_MDU_EN` undefined:
  - The ports remain, but `ex_mdu_start` and `mdu_done` are ignored.
  - The FSM stays in RUN.
  - `id_ex_write_en` is constant 1 and `mdu_timeout` is constant 0.

## Structure
- Shared package `core_pkg` holds:
  - the opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - `NOP_INSTR`;
  - the state encoding `hz_state_t` (RUN, MDU_WAIT).
- One sub-module, `rs_use_decode`: `if_id_instr` in, `rs1`/`rs2` indices and `rs1_used`/`rs2_used` out.

## Test plan
- Load-use: ID/EX `lw x5`, IF/ID `add x6,x5,x7` -> one cycle with `pc_write_en=0`, `id_ex_flush=1`, `stall_cycles=1`; normal flow the next cycle.
- No false hazard:
  - `id_ex_rd=0` with rs1=0 -> no stall.
  - `lw x5` followed by `lui x5,1` -> no stall.
- Branch over load-use: `ex_branch_taken=1` in the same cycle as a load-use -> `if_id_flush=1`, `id_ex_flush=1`, `pc_write_en=1`.
- MDU stall: `ex_mdu_start` at cycle 0, `mdu_done` at cycle 5 -> enables 0 in cycles 1..4, 1 at cycle 5, `stall_cycles=4`.
- Watchdog with `MDU_TIMEOUT=8`: `ex_mdu_start`, no `mdu_done` -> return to RUN after 8 stall cycles with `mdu_timeout=1` sticky; `rst` clears it.
- Reset in MDU_WAIT at cycle 3 -> next cycle state RUN, `stall_cycles=0`, all enables 1.
